// File: rtl/if_fetch_unit.sv
// Fetch-control stage: owns the PC, drives the synchronous instruction memory and
// registers each returned word together with its PC into the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr
);

  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic        resp_valid;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // Stalling re-requests the word already in flight, so memory returns it again.
  always_comb begin
    imem_addr = fetch_pc;
    if (reset)
      imem_addr = RESET_PC;
    else if (redirect_valid)
      imem_addr = redirect_tgt;
    else if (stall)
      imem_addr = resp_pc;
  end

  // Request side (fetch_pc/resp_pc) and IF/ID register share one edge update.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      resp_valid  <= 1'b0;
      if_valid    <= 1'b0;
      if_pc       <= 32'd0;
      if_pc_plus4 <= 32'd4;
      if_instr    <= NOP_INSTR;
    end else if (redirect_valid) begin
      resp_pc    <= redirect_tgt;
      resp_valid <= 1'b1;
      fetch_pc   <= redirect_tgt + 32'd4;
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
    end else if (!stall) begin
      if (resp_valid) begin
        if_valid    <= 1'b1;
        if_pc       <= resp_pc;
        if_pc_plus4 <= resp_pc + 32'd4;
        if_instr    <= imem_rdata;
      end else begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
      resp_pc    <= fetch_pc;
      resp_valid <= 1'b1;
      fetch_pc   <= fetch_pc + 32'd4;
    end
  end

endmodule
